// File: rtl/keypad_pkg.sv
// Shared types and constants for the CHIP-8 hex keypad scanner.
package keypad_pkg;

    // Hex key value found at row r (index 1) / column c (index 2) of the matrix.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hC},
        '{4'h4, 4'h5, 4'h6, 4'hD},
        '{4'h7, 4'h8, 4'h9, 4'hE},
        '{4'hA, 4'h0, 4'hB, 4'hF}
    };

    // FX0A wait-for-key handshake states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } keypad_state_t;

    // Index of the lowest set bit; 0 when nothing is set (callers gate on |vec).
    function automatic logic [3:0] lowest_set(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_if.sv
// FX0A wait-for-key handshake between the instruction core and the keypad.
interface keypad_if;
    logic       key_wait_req;
    logic       key_wait_ack;
    logic [3:0] key_wait_val;

    // Core side: requests a key, receives the completion pulse and value.
    modport master (
        output key_wait_req,
        input  key_wait_ack,
        input  key_wait_val
    );

    // Keypad side: serves the request.
    modport slave (
        input  key_wait_req,
        output key_wait_ack,
        output key_wait_val
    );
endinterface

// File: rtl/keypad_debounce.sv
// Per-key debouncer: the stable level flips only after the raw level has
// disagreed with it for DEBOUNCE_SCANS consecutive sample points.
module keypad_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sample_en,
    input  logic raw,
    output logic stable,
    output logic press_evt,
    output logic release_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             stable_r;
    logic             stable_nxt_s;
    logic             press_r;
    logic             press_nxt_s;
    logic             release_r;
    logic             release_nxt_s;

    // Next-state: count disagreements at sample points, flip when the count saturates.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        stable_nxt_s  = stable_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        if (sample_en) begin
            if (raw == stable_r) begin
                cnt_nxt_s = {CNT_W{1'b0}};
            end else if ((cnt_r + 1'b1) == CNT_MAX) begin
                cnt_nxt_s     = {CNT_W{1'b0}};
                stable_nxt_s  = ~stable_r;
                press_nxt_s   = ~stable_r;
                release_nxt_s = stable_r;
            end else begin
                cnt_nxt_s = cnt_r + 1'b1;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State and one-cycle event registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_r     <= {CNT_W{1'b0}};
            stable_r  <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            stable_r  <= stable_nxt_s;
            press_r   <= press_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    assign stable      = stable_r;
    assign press_evt   = press_r;
    assign release_evt = release_r;

endmodule

// File: rtl/keypad.sv
// 4x4 hex keypad: column scanner, row synchronizer, 16 debouncers and the
// FX0A wait-for-key handshake FSM.
module keypad
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] keyboard,
    keypad_if.slave     kw
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [3:0]        row_meta_r;
    logic [3:0]        row_sync_r;
    logic [SLOT_W-1:0] slot_cnt_r;
    logic [1:0]        col_idx_r;
    logic [1:0]        col_idx_nxt_s;
    logic [3:0]        col_out_r;
    logic              last_slot_s;
    logic [3:0]        sample_col_s;

    logic [15:0]       stable_rc_s;
    logic [15:0]       press_rc_s;
    logic [15:0]       release_rc_s;
    logic [15:0]       keyboard_s;
    logic [15:0]       press_s;
    logic [15:0]       release_s;

    keypad_state_t     state_r;
    keypad_state_t     state_nxt_s;
    logic              ack_r;
    logic              ack_nxt_s;
    logic [3:0]        val_r;
    logic [3:0]        val_nxt_s;

    // Two-flop synchronizer; rows idle high, so the flops reset to 1.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= row_in;
            row_sync_r <= row_meta_r;
        end
    end

    assign last_slot_s   = (slot_cnt_r == SLOT_LAST);
    assign col_idx_nxt_s = col_idx_r + 2'd1;

    // Slot counter and column drive; the column only moves after a slot's last cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
            col_idx_r  <= 2'd0;
            col_out_r  <= 4'b1110;
        end else if (last_slot_s) begin
            slot_cnt_r <= {SLOT_W{1'b0}};
            col_idx_r  <= col_idx_nxt_s;
            col_out_r  <= ~(4'b0001 << col_idx_nxt_s);
        end else begin
            slot_cnt_r <= slot_cnt_r + 1'b1;
        end
    end

    // Sample strobe for the keys of the currently driven column.
    always_comb begin
        sample_col_s = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            sample_col_s[c] = last_slot_s && (col_idx_r == 2'(c));
        end
    end

    // One debouncer per matrix position, indexed r*4+c; a low row means pressed.
    for (genvar gr = 0; gr < 4; gr++) begin : g_row
        for (genvar gc = 0; gc < 4; gc++) begin : g_col
            keypad_debounce #(
                .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
            ) u_deb (
                .clk_in      (clk_in),
                .rst_in      (rst_in),
                .sample_en   (sample_col_s[gc]),
                .raw         (~row_sync_r[gr]),
                .stable      (stable_rc_s[gr*4+gc]),
                .press_evt   (press_rc_s[gr*4+gc]),
                .release_evt (release_rc_s[gr*4+gc])
            );
        end
    end

    // Permute matrix positions into hex-key order.
    always_comb begin
        keyboard_s = 16'h0000;
        press_s    = 16'h0000;
        release_s  = 16'h0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                keyboard_s[KEY_MAP[r][c]] = stable_rc_s[r*4+c];
                press_s[KEY_MAP[r][c]]    = press_rc_s[r*4+c];
                release_s[KEY_MAP[r][c]]  = release_rc_s[r*4+c];
            end
        end
    end

    // FX0A next state: arm on req, latch the first new press, ack on its release.
    always_comb begin
        state_nxt_s = state_r;
        ack_nxt_s   = 1'b0;
        val_nxt_s   = val_r;
        case (state_r)
            IDLE: begin
                if (kw.key_wait_req) begin
                    state_nxt_s = ARMED;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ARMED: begin
                if (!kw.key_wait_req) begin
                    state_nxt_s = IDLE;
                end else if (|press_s) begin
                    val_nxt_s   = lowest_set(press_s);
                    state_nxt_s = HELD;
                end else begin
                    state_nxt_s = ARMED;
                end
            end
            HELD: begin
                if (!kw.key_wait_req) begin
                    state_nxt_s = IDLE;
                end else if (release_s[val_r]) begin
                    ack_nxt_s   = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FX0A state, ack pulse and latched key value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= IDLE;
            ack_r   <= 1'b0;
            val_r   <= 4'h0;
        end else begin
            state_r <= state_nxt_s;
            ack_r   <= ack_nxt_s;
            val_r   <= val_nxt_s;
        end
    end

    assign col_out         = col_out_r;
    assign keyboard        = keyboard_s;
    assign kw.key_wait_ack = ack_r;
    assign kw.key_wait_val = val_r;

endmodule
